// File: rtl/lane_deskew.sv
// ---------------------------------------------------------------------------
// lane_deskew
//
// Re-aligns LANS parallel lanes that arrive with independent skew. Each lane
// writes its beats into its own small FIFO. While hunting, every lane
// discards beats until an alignment marker reaches the head of its FIFO. The
// marker is BPL bytes of 8'hBC, all flagged as K characters. When every lane
// shows a marker at the same time, the lanes are locked together. From then
// on, one beat is taken from every lane per cycle. Inconsistent markers or a
// FIFO overflow drop the lock and restart the hunt with empty FIFOs.
//
// Ports
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   in_dat    raw bytes, lane i at [i*BPL*8 +: BPL*8]
//   in_datk   K flag per byte, lane i at [i*BPL +: BPL]
//   in_datv   per-lane beat valid
//   rdat      deskewed bytes, same packing as in_dat
//   rdatk     deskewed K flags, same packing as in_datk
//   rdatv     deskewed beat valid (all bits identical)
//   aligned   high while the lanes are locked
//   skew_err  one-cycle pulse when marker alignment fails
//   ovf_err   one-cycle pulse when a lane FIFO overflows
// ---------------------------------------------------------------------------
module lane_deskew #(
   parameter int LANS  = 4,
   parameter int BPL   = 4,
   parameter int DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [LANS*BPL*8-1:0] in_dat,
   input  logic [LANS*BPL-1:0]   in_datk,
   input  logic [LANS-1:0]       in_datv,
   output logic [LANS*BPL*8-1:0] rdat,
   output logic [LANS*BPL-1:0]   rdatk,
   output logic [LANS-1:0]       rdatv,
   output logic                  aligned,
   output logic                  skew_err,
   output logic                  ovf_err
);

   localparam int BW = BPL * 8;
   localparam int AW = $clog2(DEPTH);
   localparam logic [BW-1:0] MARKER_DAT = {BPL{8'hBC}};

   typedef enum logic {
      HUNT    = 1'b0,
      ALIGNED = 1'b1
   } state_t;

   state_t state, state_nxt;

   logic [BW-1:0]  mem_dat [LANS][DEPTH];
   logic [BPL-1:0] mem_k   [LANS][DEPTH];
   logic [AW:0]    wr_ptr  [LANS];
   logic [AW:0]    rd_ptr  [LANS];

   logic [LANS-1:0]     empty;
   logic [LANS-1:0]     full;
   logic [LANS-1:0]     head_mk;
   logic [LANS-1:0]     pop;
   logic [LANS-1:0]     push_ok;
   logic [LANS*BW-1:0]  head_dat;
   logic [LANS*BPL-1:0] head_k;
   logic                fwd;
   logic                fwd_q;
   logic                skew_det;
   logic                ovf_det;
   logic                flush;

   // Per-lane FIFO status and head-of-FIFO view. The pointers carry one extra
   // wrap bit, so a full FIFO and an empty FIFO can be told apart even when
   // the address bits match.
   always_comb begin
      empty    = '0;
      full     = '0;
      head_mk  = '0;
      head_dat = '0;
      head_k   = '0;
      for (int i = 0; i < LANS; i++) begin
         empty[i] = (wr_ptr[i] == rd_ptr[i]);
         full[i]  = (wr_ptr[i][AW] != rd_ptr[i][AW]) &&
                    (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
         head_dat[i*BW +: BW]   = mem_dat[i][rd_ptr[i][AW-1:0]];
         head_k[i*BPL +: BPL]   = mem_k[i][rd_ptr[i][AW-1:0]];
         head_mk[i] = (wr_ptr[i] != rd_ptr[i]) &&
                      (mem_dat[i][rd_ptr[i][AW-1:0]] == MARKER_DAT) &&
                      (&mem_k[i][rd_ptr[i][AW-1:0]]);
      end
   end

   // Pop, forward and error decisions.
   // In HUNT, each lane discards non-marker beats on its own. A lane holds
   // once a marker reaches its head. If a holding lane fills up before the
   // other lanes catch up, the skew exceeds what the FIFOs can absorb.
   // In ALIGNED, lanes only move together. A beat set with markers on some
   // lanes but not others means the lock was lost; that set is swallowed.
   // An overflow is a push into a full FIFO that is not popping this cycle.
   always_comb begin
      state_nxt = state;
      pop       = '0;
      fwd       = 1'b0;
      skew_det  = 1'b0;
      ovf_det   = 1'b0;
      case (state)
         HUNT: begin
            if (&head_mk) begin
               pop       = '1;
               fwd       = 1'b1;
               state_nxt = ALIGNED;
            end else begin
               pop      = ~empty & ~head_mk;
               skew_det = |(full & head_mk);
            end
         end
         ALIGNED: begin
            if (~|empty) begin
               pop = '1;
               if ((|head_mk) && !(&head_mk)) begin
                  skew_det = 1'b1;
               end else begin
                  fwd = 1'b1;
               end
            end
         end
         default: state_nxt = HUNT;
      endcase
      ovf_det = |(in_datv & full & ~pop);
      flush   = skew_det | ovf_det;
      push_ok = in_datv & (~full | pop);
      if (flush) begin
         state_nxt = HUNT;
      end
   end

   // FIFO pointers. A flush empties every lane at the edge that ends the
   // error cycle. Pushes and pops from that same cycle are discarded.
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         for (int i = 0; i < LANS; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
         end
      end else begin
         for (int i = 0; i < LANS; i++) begin
            if (push_ok[i]) begin
               wr_ptr[i] <= wr_ptr[i] + 1'b1;
            end
            if (pop[i]) begin
               rd_ptr[i] <= rd_ptr[i] + 1'b1;
            end
         end
      end
   end

   // FIFO storage. This block has no reset because the pointers alone decide
   // which entries are valid. When a full FIFO is popped and pushed in the
   // same cycle, the write lands in the slot being freed. That is safe,
   // because the head was already read combinationally during the cycle.
   always_ff @(posedge clk) begin
      for (int i = 0; i < LANS; i++) begin
         if (push_ok[i]) begin
            mem_dat[i][wr_ptr[i][AW-1:0]] <= in_dat[i*BW +: BW];
            mem_k[i][wr_ptr[i][AW-1:0]]   <= in_datk[i*BPL +: BPL];
         end
      end
   end

   // State register and registered outputs. A forwarded beat set appears
   // one cycle after its pop. When nothing is forwarded, the data outputs
   // hold their previous value.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= HUNT;
         rdat     <= '0;
         rdatk    <= '0;
         fwd_q    <= 1'b0;
         skew_err <= 1'b0;
         ovf_err  <= 1'b0;
      end else begin
         state    <= state_nxt;
         fwd_q    <= fwd;
         skew_err <= skew_det;
         ovf_err  <= ovf_det;
         if (fwd) begin
            rdat  <= head_dat;
            rdatk <= head_k;
         end
      end
   end

   assign rdatv   = {LANS{fwd_q}};
   assign aligned = (state == ALIGNED);

endmodule

// File: tb/tb_lane_deskew.sv
// ---------------------------------------------------------------------------
// tb_lane_deskew
//
// Directed testbench for lane_deskew. Stimulus is staged per lane and then
// applied on the falling clock edge. A queue-style model keeps each lane as
// a plain array plus a count, and works out what the outputs must be after
// the next rising edge. A compare process checks the DUT against the model
// on every falling edge. A few hand-computed literal checks pin the key
// cycles of each scenario.
// ---------------------------------------------------------------------------
module tb_lane_deskew;

   localparam int LANS  = 4;
   localparam int BPL   = 4;
   localparam int DEPTH = 8;
   localparam logic [31:0] MK = 32'hBCBCBCBC;

   logic         clk;
   logic         rst_n;
   logic [127:0] in_dat;
   logic [15:0]  in_datk;
   logic [3:0]   in_datv;
   logic [127:0] rdat;
   logic [15:0]  rdatk;
   logic [3:0]   rdatv;
   logic         aligned;
   logic         skew_err;
   logic         ovf_err;

   int tests    = 0;
   int failures = 0;
   int cyc      = 0;
   bit chkEn    = 0;

   // Staged stimulus, copied to the DUT pins on the next falling edge.
   bit          sRst;
   logic [3:0]  sV;
   bit          sMk  [LANS];
   logic [31:0] sDat [LANS];

   // Model: lane contents as shift arrays, plus the expected outputs.
   logic [31:0]  mDat [LANS][DEPTH];
   logic [3:0]   mK   [LANS][DEPTH];
   int           mCnt [LANS];
   bit           mAligned;
   logic [127:0] eDat;
   logic [15:0]  eK;
   bit           eV;
   bit           eSkew;
   bit           eOvf;

   lane_deskew #(
      .LANS  (LANS),
      .BPL   (BPL),
      .DEPTH (DEPTH)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_dat   (in_dat),
      .in_datk  (in_datk),
      .in_datv  (in_datv),
      .rdat     (rdat),
      .rdatk    (rdatk),
      .rdatv    (rdatv),
      .aligned  (aligned),
      .skew_err (skew_err),
      .ovf_err  (ovf_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   // Advance the model by one rising edge, using the inputs now on the pins.
   task automatic modelStep();
      bit hm [LANS];
      bit pp [LANS];
      bit fwd, skw, ovf, nxt;
      int nm, nNe;
      fwd = 0; skw = 0; ovf = 0; nxt = mAligned; nm = 0; nNe = 0;
      if (!rst_n) begin
         for (int i = 0; i < LANS; i++) mCnt[i] = 0;
         mAligned = 0; eDat = '0; eK = '0; eV = 0; eSkew = 0; eOvf = 0;
         return;
      end
      for (int i = 0; i < LANS; i++) begin
         pp[i] = 0;
         hm[i] = (mCnt[i] > 0) && (mDat[i][0] == MK) && (mK[i][0] == 4'hF);
         if (hm[i]) nm++;
         if (mCnt[i] > 0) nNe++;
      end
      if (!mAligned) begin
         if (nm == LANS) begin
            for (int i = 0; i < LANS; i++) pp[i] = 1;
            fwd = 1;
            nxt = 1;
         end else begin
            for (int i = 0; i < LANS; i++) begin
               if (mCnt[i] > 0 && !hm[i]) pp[i] = 1;
               if (mCnt[i] == DEPTH && hm[i]) skw = 1;
            end
         end
      end else if (nNe == LANS) begin
         for (int i = 0; i < LANS; i++) pp[i] = 1;
         if (nm > 0 && nm < LANS) skw = 1;
         else fwd = 1;
      end
      for (int i = 0; i < LANS; i++)
         if (in_datv[i] && mCnt[i] == DEPTH && !pp[i]) ovf = 1;
      eV = fwd; eSkew = skw; eOvf = ovf;
      if (fwd) begin
         for (int i = 0; i < LANS; i++) begin
            eDat[i*32 +: 32] = mDat[i][0];
            eK[i*4 +: 4]     = mK[i][0];
         end
      end
      if (skw || ovf) begin
         for (int i = 0; i < LANS; i++) mCnt[i] = 0;
         mAligned = 0;
      end else begin
         mAligned = nxt;
         for (int i = 0; i < LANS; i++) begin
            if (pp[i]) begin
               for (int j = 0; j < DEPTH - 1; j++) begin
                  mDat[i][j] = mDat[i][j+1];
                  mK[i][j]   = mK[i][j+1];
               end
               mCnt[i]--;
            end
            if (in_datv[i]) begin
               mDat[i][mCnt[i]] = in_dat[i*32 +: 32];
               mK[i][mCnt[i]]   = in_datk[i*4 +: 4];
               mCnt[i]++;
            end
         end
      end
   endtask

   task automatic checkOutput();
      cmp("rdatv", {124'd0, rdatv}, {124'd0, {4{eV}}});
      cmp("aligned", {127'd0, aligned}, {127'd0, mAligned});
      cmp("skew_err", {127'd0, skew_err}, {127'd0, eSkew});
      cmp("ovf_err", {127'd0, ovf_err}, {127'd0, eOvf});
      cmp("rdat", rdat, eDat);
      cmp("rdatk", {112'd0, rdatk}, {112'd0, eK});
   endtask

   // One compare process: on each falling edge, outputs from the last rising
   // edge are checked against the model.
   always @(negedge clk) begin
      if (chkEn) checkOutput();
   end

   task automatic setLane(input int i, input bit v, input bit m, input logic [31:0] val);
      sV[i]   = v;
      sMk[i]  = m;
      sDat[i] = val;
   endtask

   task automatic allLanes(input bit m, input logic [31:0] val);
      for (int i = 0; i < LANS; i++) setLane(i, 1'b1, m, val);
   endtask

   task automatic applyStimulus();
      @(negedge clk);
      rst_n = sRst;
      for (int i = 0; i < LANS; i++) begin
         in_dat[i*32 +: 32] = sMk[i] ? MK : sDat[i];
         in_datk[i*4 +: 4]  = sMk[i] ? 4'hF : 4'h0;
      end
      in_datv = sV;
      #1;
      modelStep();
      cyc++;
   endtask

   task automatic runIdle(input int n);
      sV = '0;
      repeat (n) applyStimulus();
   endtask

   initial begin
      rst_n = 1'b0; in_dat = '0; in_datk = '0; in_datv = '0;
      sRst = 1'b0; sV = '0;
      for (int i = 0; i < LANS; i++) begin sMk[i] = 0; sDat[i] = '0; mCnt[i] = 0; end
      mAligned = 0; eDat = '0; eK = '0; eV = 0; eSkew = 0; eOvf = 0;

      // Reset
      applyStimulus();
      chkEn = 1;
      applyStimulus();
      cmp("lit_reset_rdatv", {124'd0, rdatv}, 128'h0);
      cmp("lit_reset_aligned", {127'd0, aligned}, 128'h0);
      cmp("lit_reset_rdat", rdat, 128'h0);
      sRst = 1'b1;

      // Zero skew: markers at cycle 0, then data 1..5
      allLanes(1'b1, 32'h0);
      applyStimulus();
      allLanes(1'b0, 32'h1);
      applyStimulus();
      cmp("lit_zs_c1_rdatv", {124'd0, rdatv}, 128'h0);
      allLanes(1'b0, 32'h2);
      applyStimulus();
      cmp("lit_zs_c2_rdatv", {124'd0, rdatv}, 128'hF);
      cmp("lit_zs_c2_aligned", {127'd0, aligned}, 128'h1);
      cmp("lit_zs_c2_rdat", rdat, {4{32'hBCBCBCBC}});
      cmp("lit_zs_c2_rdatk", {112'd0, rdatk}, 128'hFFFF);
      allLanes(1'b0, 32'h3);
      applyStimulus();
      cmp("lit_zs_c3_rdat", rdat, {4{32'h00000001}});
      cmp("lit_zs_c3_rdatk", {112'd0, rdatk}, 128'h0);
      allLanes(1'b0, 32'h4);
      applyStimulus();
      allLanes(1'b0, 32'h5);
      applyStimulus();
      runIdle(3);

      // Markers on lanes 0,1 only while aligned
      setLane(0, 1, 1, 0); setLane(1, 1, 1, 0);
      setLane(2, 1, 0, 32'h10); setLane(3, 1, 0, 32'h10);
      applyStimulus();
      runIdle(2);
      cmp("lit_mis_skew", {127'd0, skew_err}, 128'h1);
      cmp("lit_mis_rdatv", {124'd0, rdatv}, 128'h0);
      cmp("lit_mis_aligned", {127'd0, aligned}, 128'h0);
      runIdle(1);
      cmp("lit_mis_skew_clear", {127'd0, skew_err}, 128'h0);

      // Lane 2 delayed by three beats
      for (int c = 0; c < 10; c++) begin
         for (int i = 0; i < LANS; i++) begin
            int b;
            b = (i == 2) ? c - 3 : c;
            if (b >= 0 && b <= 6) setLane(i, 1, (b == 0), 32'(b));
            else setLane(i, 0, 0, 32'h0);
         end
         applyStimulus();
         if (c == 5) begin
            cmp("lit_sk3_aligned", {127'd0, aligned}, 128'h1);
            cmp("lit_sk3_marker", rdat, {4{32'hBCBCBCBC}});
         end
      end
      runIdle(4);
      cmp("lit_sk3_last", rdat, {4{32'h00000006}});

      // Overflow: lane 0 silent for DEPTH+1 beats
      for (int c = 0; c <= DEPTH; c++) begin
         setLane(0, 0, 0, 0);
         for (int i = 1; i < LANS; i++) setLane(i, 1, 0, 32'h100 + 32'(c));
         applyStimulus();
      end
      runIdle(1);
      cmp("lit_ovf_pulse", {127'd0, ovf_err}, 128'h1);
      cmp("lit_ovf_aligned", {127'd0, aligned}, 128'h0);
      cmp("lit_ovf_rdatv", {124'd0, rdatv}, 128'h0);
      runIdle(1);
      cmp("lit_ovf_clear", {127'd0, ovf_err}, 128'h0);

      // Skew beyond DEPTH: only lane 0 carries a marker
      for (int c = 0; c < 10; c++) begin
         allLanes(1'b0, 32'h200 + 32'(c));
         if (c == 0) setLane(0, 1, 1, 0);
         applyStimulus();
      end
      cmp("lit_deep_skew", {127'd0, skew_err}, 128'h1);
      cmp("lit_deep_aligned", {127'd0, aligned}, 128'h0);
      runIdle(1);
      cmp("lit_deep_clear", {127'd0, skew_err}, 128'h0);
      runIdle(2);

      // Reset with five beats buffered
      allLanes(1'b1, 32'h0);
      applyStimulus();
      for (int c = 1; c <= 5; c++) begin
         setLane(0, 0, 0, 0);
         for (int i = 1; i < LANS; i++) setLane(i, 1, 0, 32'h300 + 32'(c));
         applyStimulus();
      end
      sRst = 1'b0;
      runIdle(1);
      sRst = 1'b1;
      runIdle(1);
      cmp("lit_rst_rdat", rdat, 128'h0);
      cmp("lit_rst_rdatk", {112'd0, rdatk}, 128'h0);
      cmp("lit_rst_aligned", {127'd0, aligned}, 128'h0);
      for (int c = 0; c < 3; c++) begin
         sV = '0;
         setLane(0, 1, 0, 32'h3FF);
         applyStimulus();
      end
      runIdle(2);
      cmp("lit_rst_no_rdatv", {124'd0, rdatv}, 128'h0);
      allLanes(1'b1, 32'h0);
      applyStimulus();
      runIdle(2);
      cmp("lit_rst_realign", {127'd0, aligned}, 128'h1);

      // Push and pop on full FIFOs in the same cycle
      for (int c = 0; c < 12; c++) begin
         for (int i = 1; i < LANS; i++) setLane(i, 1, 0, 32'h400 + 32'(c));
         if (c >= 7) setLane(0, 1, 0, 32'h400 + 32'(c));
         else setLane(0, 0, 0, 0);
         applyStimulus();
         if (c == 9) begin
            cmp("lit_full_ovf", {127'd0, ovf_err}, 128'h0);
            cmp("lit_full_aligned", {127'd0, aligned}, 128'h1);
            cmp("lit_full_rdat", rdat, {32'h400, 32'h400, 32'h400, 32'h407});
         end
      end
      runIdle(3);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule

// File: doc/lane_deskew.md
LANE_DESKEW -- requirements
Module: lane_deskew

Interface
REQ-001 SHALL have parameter LANS, default 4, number of lanes.
REQ-002 SHALL have parameter BPL, default 4, bytes per lane per beat.
REQ-003 SHALL have parameter DEPTH, default 8, per-lane FIFO depth in beats (power of 2, >=4).
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port in_dat  input  LANS*BPL*8  raw per-lane bytes; lane i at [i*BPL*8 +: BPL*8].
REQ-007 SHALL have port in_datk  input  LANS*BPL  K flag per byte; lane i at [i*BPL +: BPL].
REQ-008 SHALL have port in_datv  input  LANS  per-lane beat valid.
REQ-009 SHALL have port rdat  output  LANS*BPL*8  deskewed bytes, same lane packing.
REQ-010 SHALL have port rdatk  output  LANS*BPL  deskewed K flags.
REQ-011 SHALL have port rdatv  output  LANS  deskewed valid; all bits always equal.
REQ-012 SHALL have port aligned  output  1  high while state is ALIGNED.
REQ-013 SHALL have port skew_err  output  1  one-cycle pulse on skew/alignment failure.
REQ-014 SHALL have port ovf_err  output  1  one-cycle pulse on FIFO overflow.

Function
REQ-015 SHALL define a marker beat as all BPL bytes == 8'hBC with all BPL K flags set.
REQ-016 SHALL keep one DEPTH-beat FIFO per lane; push lane i when in_datv[i]=1, regardless of state.
REQ-017 SHALL implement states HUNT and ALIGNED; reset state HUNT.
REQ-018 HUNT: SHALL pop, per lane independently, any non-empty FIFO whose head is not a marker; a lane with a marker at its head holds.
REQ-019 HUNT: when all lanes hold a marker at head in the same cycle, SHALL pop all lanes together, forward that beat set, and enter ALIGNED next cycle.
REQ-020 HUNT: if any lane FIFO is full while holding a marker and not all lanes hold markers, SHALL pulse skew_err, flush all FIFOs, and remain in HUNT.
REQ-021 ALIGNED: when all FIFOs are non-empty, SHALL pop all lanes in the same cycle and forward the beat set; otherwise SHALL not pop.
REQ-022 ALIGNED: if a popped beat set has markers on some but not all lanes, SHALL suppress its output, pulse skew_err, flush all FIFOs, and enter HUNT.
REQ-023 SHALL register forwarded beats: rdat/rdatk update and rdatv=all-ones exactly one cycle after the pop; otherwise rdatv=0 and rdat/rdatk hold.
REQ-024 Minimum latency from in_datv to rdatv SHALL be 2 cycles in ALIGNED with empty FIFOs.
REQ-025 Push to a full FIFO with no same-cycle pop SHALL drop the beat, pulse ovf_err, flush all FIFOs, and enter HUNT; push and pop on a full FIFO in the same cycle SHALL be lossless.
REQ-026 Flush SHALL take effect in the cycle after the error; same-cycle pushes at the error cycle SHALL be discarded.
REQ-027 If skew_err and ovf_err conditions coincide, SHALL pulse both.
REQ-028 FIFO pointers SHALL wrap modulo DEPTH with a separate full/empty distinction (extra pointer bit or count).

Reset
REQ-029 On rst_n=0 at a clock edge SHALL clear: rdat=0, rdatk=0, rdatv=0, aligned=0, skew_err=0, ovf_err=0, all FIFOs empty, state HUNT.
REQ-030 Reset mid-operation SHALL discard all buffered beats; no rdatv pulse SHALL follow from pre-reset data.

Verification
REQ-031 Zero skew: marker on all 4 lanes at cycle 0, then data 32'h00000001.. per lane -> rdatv with marker at cycle 2, aligned=1 at cycle 2, data 1 at cycle 3.
REQ-032 Skew 3: lane 2 delayed 3 beats vs others, marker then incrementing data -> aligned after lane 2 marker arrives; rdat lanes carry equal data values every rdatv cycle.
REQ-033 Skew beyond DEPTH: lane 0 marker at cycle 0, other lanes no marker for 10 beats -> skew_err pulse once lane 0 FIFO full, FIFOs flushed, aligned=0.
REQ-034 Marker misalignment in ALIGNED: after alignment, marker on lanes 0,1 only -> skew_err=1 one cycle, no rdatv for that set, aligned=0 next cycle.
REQ-035 Overflow: aligned, in_datv=4'b1110 for DEPTH+1 beats -> ovf_err pulse, aligned=0, rdatv=0.
REQ-036 Reset mid-stream: rst_n=0 one cycle with 5 beats buffered -> all outputs 0, no rdatv until a new marker set is received.
